// File: rtl/spi_cmd_master.sv
// SPI mode-3 master sending 16-bit cmd/value word pairs MSB first.
// Ports: CLK/RST_N; start/single/cmd/value request; busy/done status;
// rx_word0/rx_word1 captured MISO; SCK/SCSN/MOSI/MISO serial bus.
module spi_cmd_master #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        single,
    input  logic [15:0] cmd,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_word0,
    output logic [15:0] rx_word1,
    output logic        SCK,
    output logic        SCSN,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_HOLD, S_DESEL
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic        word_q, word_d;
    logic        single_q, single_d;
    logic [15:0] cmd_q, cmd_d;
    logic [15:0] val_q, val_d;
    logic [15:0] sh0_q, sh0_d;
    logic [15:0] sh1_q, sh1_d;
    logic [15:0] rx0_q, rx0_d;
    logic [15:0] rx1_q, rx1_d;
    logic        sck_q, sck_d;
    logic        scsn_q, scsn_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] cur_word;
    logic [3:0]  bit_nxt;

    assign cur_word = word_q ? val_q : cmd_q;
    assign bit_nxt  = bit_q - 4'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        word_d   = word_q;
        single_d = single_q;
        cmd_d    = cmd_q;
        val_d    = val_q;
        sh0_d    = sh0_q;
        sh1_d    = sh1_q;
        rx0_d    = rx0_q;
        rx1_d    = rx1_q;
        sck_d    = sck_q;
        scsn_d   = scsn_q;
        mosi_d   = mosi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                sck_d  = 1'b1;
                scsn_d = 1'b1;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    cmd_d    = cmd;
                    val_d    = value;
                    single_d = single;
                    bit_d    = 4'd15;
                    word_d   = 1'b0;
                    cnt_d    = DIV_LD;
                    scsn_d   = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    sck_d   = 1'b0;
                    mosi_d  = cmd_q[15];
                    cnt_d   = DIV_LD;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!sck_q) begin
                    // Rising SCK: the slave has driven MISO since the fall.
                    sck_d = 1'b1;
                    cnt_d = DIV_LD;
                    if (word_q) sh1_d = {sh1_q[14:0], MISO};
                    else        sh0_d = {sh0_q[14:0], MISO};
                end else if (bit_q == 4'd0) begin
                    if (word_q) rx1_d = sh1_q;
                    else        rx0_d = sh0_q;
                    if (!word_q && !single_q) begin
                        cnt_d   = GAP_LD;
                        state_d = S_GAP;
                    end else begin
                        cnt_d   = DIV_LD;
                        state_d = S_HOLD;
                    end
                end else begin
                    bit_d  = bit_nxt;
                    sck_d  = 1'b0;
                    mosi_d = cur_word[bit_nxt];
                    cnt_d  = DIV_LD;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    word_d  = 1'b1;
                    bit_d   = 4'd15;
                    sck_d   = 1'b0;
                    mosi_d  = val_q[15];
                    cnt_d   = DIV_LD;
                    state_d = S_SHIFT;
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    scsn_d  = 1'b1;
                    mosi_d  = 1'b0;
                    cnt_d   = DIV_LD;
                    state_d = S_DESEL;
                end
            end
            S_DESEL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // done and busy fall land together on the exit edge
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            word_q   <= 1'b0;
            single_q <= 1'b0;
            cmd_q    <= '0;
            val_q    <= '0;
            sh0_q    <= '0;
            sh1_q    <= '0;
            rx0_q    <= '0;
            rx1_q    <= '0;
            sck_q    <= 1'b1;
            scsn_q   <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            single_q <= single_d;
            cmd_q    <= cmd_d;
            val_q    <= val_d;
            sh0_q    <= sh0_d;
            sh1_q    <= sh1_d;
            rx0_q    <= rx0_d;
            rx1_q    <= rx1_d;
            sck_q    <= sck_d;
            scsn_q   <= scsn_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign SCK      = sck_q;
    assign SCSN     = scsn_q;
    assign MOSI     = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_word0 = rx0_q;
    assign rx_word1 = rx1_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Testbench for spi_cmd_master: slave model scoreboard plus
// per-scenario timing and data checks at default parameters.
module tb_spi_cmd_master;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        single = 1'b0;
    logic [15:0] cmd = '0;
    logic [15:0] value = '0;
    logic        busy, done, SCK, SCSN, MOSI, MISO;
    logic [15:0] rx_word0, rx_word1;

    logic loop_mode = 1'b0;
    logic miso_const = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];

    assign MISO = loop_mode ? MOSI : miso_const;

    always #5 CLK = ~CLK;

    spi_cmd_master #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .single(single),
        .cmd(cmd), .value(value), .busy(busy), .done(done),
        .rx_word0(rx_word0), .rx_word1(rx_word1),
        .SCK(SCK), .SCSN(SCSN), .MOSI(MOSI), .MISO(MISO)
    );

    // Slave model: samples MOSI on SCK rise while selected.
    logic        m_prev_sck = 1'b1;
    int          m_bits = 0;
    logic [15:0] m_sh = '0;
    always @(negedge CLK) begin
        if (!RST_N || SCSN) begin
            m_bits = 0;
        end else if (SCK && !m_prev_sck) begin
            m_sh = {m_sh[14:0], MOSI};
            m_bits++;
            if (m_bits == 16) begin
                logic [15:0] e;
                m_bits = 0;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL slave_word unexpected got=%h", m_sh);
                end else begin
                    e = exp_q.pop_front();
                    if (m_sh !== e) begin
                        n_fail++;
                        $display("FAIL slave_word got=%h exp=%h", m_sh, e);
                    end
                end
            end
        end
        m_prev_sck = SCK;
    end

    task automatic run_frame(
        input  logic [15:0] c,
        input  logic [15:0] v,
        input  logic        s,
        input  int          inject_at,
        output int          low,
        output int          rise_at,
        output int          done_at,
        output int          dcount,
        output int          rises,
        output logic [15:0] r0,
        output logic [15:0] r1
    );
        logic p_scsn, p_sck;
        bit ok;
        low = 0; rise_at = -1; done_at = -1; dcount = 0; rises = 0;
        r0 = '0; r1 = '0; ok = 0;
        @(negedge CLK);
        cmd = c; value = v; single = s; start = 1'b1;
        p_scsn = SCSN; p_sck = SCK;
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            if (k == inject_at) begin
                start = 1'b1; cmd = 16'hDEAD; value = 16'hBEEF; single = 1'b1;
            end else if (k == 0 || k == inject_at + 1) begin
                start = 1'b0;
            end
            if (!SCSN) low++;
            if (SCSN && !p_scsn) rise_at = k;
            if (SCK && !p_sck) rises++;
            if (done) begin
                dcount++;
                if (done_at < 0) begin
                    done_at = k; r0 = rx_word0; r1 = rx_word1;
                end
            end
            p_scsn = SCSN; p_sck = SCK;
            if (done_at >= 0 && k >= done_at + 3) begin
                ok = 1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL frame_timeout done_at=%0d exp=done within 400", done_at);
        end
    endtask

    task automatic test_reset();
        bit sck_ok;
        sck_ok = 1;
        RST_N = 1'b0; start = 1'b1; cmd = 16'h1234; value = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (SCK !== 1'b1) sck_ok = 0;
        end
        n_tests += 8;
        if (!sck_ok) begin n_fail++; $display("FAIL rst_sck_toggle got=0 exp=1"); end
        if (SCK !== 1'b1) begin n_fail++; $display("FAIL rst_sck got=%b exp=1", SCK); end
        if (SCSN !== 1'b1) begin n_fail++; $display("FAIL rst_scsn got=%b exp=1", SCSN); end
        if (MOSI !== 1'b0) begin n_fail++; $display("FAIL rst_mosi got=%b exp=0", MOSI); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
        if (rx_word0 !== 16'h0) begin n_fail++; $display("FAIL rst_rx0 got=%h exp=0", rx_word0); end
        if (rx_word1 !== 16'h0) begin n_fail++; $display("FAIL rst_rx1 got=%h exp=0", rx_word1); end
        start = 1'b0;
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_pair();
        int low, ra, da, dc, rs;
        logic [15:0] r0, r1;
        loop_mode = 1'b0; miso_const = 1'b0;
        exp_q.push_back(16'h0003);
        exp_q.push_back(16'h0064);
        run_frame(16'h0003, 16'd100, 1'b0, -1, low, ra, da, dc, rs, r0, r1);
        n_tests += 5;
        if (low != 136) begin n_fail++; $display("FAIL pair_scsn_low got=%0d exp=136", low); end
        if (da - ra != 2) begin n_fail++; $display("FAIL pair_done_delay got=%0d exp=2", da - ra); end
        if (dc != 1) begin n_fail++; $display("FAIL pair_done_count got=%0d exp=1", dc); end
        if (rs != 32) begin n_fail++; $display("FAIL pair_sck_rises got=%0d exp=32", rs); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL pair_words_left got=%0d exp=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_loopback();
        int low, ra, da, dc, rs;
        logic [15:0] r0, r1;
        loop_mode = 1'b1;
        exp_q.push_back(16'hA5C3);
        exp_q.push_back(16'h1234);
        run_frame(16'hA5C3, 16'h1234, 1'b0, -1, low, ra, da, dc, rs, r0, r1);
        n_tests += 2;
        if (r0 !== 16'hA5C3) begin n_fail++; $display("FAIL loop_rx0 got=%h exp=a5c3", r0); end
        if (r1 !== 16'h1234) begin n_fail++; $display("FAIL loop_rx1 got=%h exp=1234", r1); end
        exp_q.delete();
    endtask

    task automatic test_single();
        int low, ra, da, dc, rs;
        logic [15:0] r0, r1;
        loop_mode = 1'b0; miso_const = 1'b0;
        exp_q.push_back(16'hFFFF);
        run_frame(16'hFFFF, 16'hAAAA, 1'b1, -1, low, ra, da, dc, rs, r0, r1);
        n_tests += 5;
        if (low != 68) begin n_fail++; $display("FAIL single_scsn_low got=%0d exp=68", low); end
        if (rs != 16) begin n_fail++; $display("FAIL single_sck_rises got=%0d exp=16", rs); end
        if (r0 !== 16'h0000) begin n_fail++; $display("FAIL single_rx0 got=%h exp=0000", r0); end
        if (r1 !== 16'h1234) begin n_fail++; $display("FAIL single_rx1 got=%h exp=1234", r1); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_words_left got=%0d exp=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_start_while_busy();
        int low, ra, da, dc, rs;
        logic [15:0] r0, r1;
        loop_mode = 1'b1;
        exp_q.push_back(16'h5A5A);
        exp_q.push_back(16'h0F0F);
        run_frame(16'h5A5A, 16'h0F0F, 1'b0, 40, low, ra, da, dc, rs, r0, r1);
        repeat (5) @(negedge CLK);
        n_tests += 5;
        if (r0 !== 16'h5A5A) begin n_fail++; $display("FAIL busy_rx0 got=%h exp=5a5a", r0); end
        if (r1 !== 16'h0F0F) begin n_fail++; $display("FAIL busy_rx1 got=%h exp=0f0f", r1); end
        if (low != 136) begin n_fail++; $display("FAIL busy_scsn_low got=%0d exp=136", low); end
        if (dc != 1) begin n_fail++; $display("FAIL busy_done_count got=%0d exp=1", dc); end
        if (busy !== 1'b0 || SCSN !== 1'b1) begin
            n_fail++; $display("FAIL busy_queued got busy=%b scsn=%b exp busy=0 scsn=1", busy, SCSN);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic p_scsn;
        int rise_at, fall_at, dc, last;
        rise_at = -1; fall_at = -1; dc = 0; last = -1;
        loop_mode = 1'b0; miso_const = 1'b1;
        repeat (2) begin
            exp_q.push_back(16'h1111);
            exp_q.push_back(16'h2222);
        end
        @(negedge CLK);
        cmd = 16'h1111; value = 16'h2222; single = 1'b0; start = 1'b1;
        p_scsn = SCSN;
        for (int k = 0; k < 600; k++) begin
            @(negedge CLK);
            if (SCSN && !p_scsn && rise_at < 0) rise_at = k;
            if (!SCSN && p_scsn && rise_at >= 0 && fall_at < 0) begin
                fall_at = k;
                start = 1'b0;
            end
            if (done) dc++;
            p_scsn = SCSN;
            if (dc == 2) begin
                last = k;
                break;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge CLK);
        n_tests += 4;
        if (last < 0) begin n_fail++; $display("FAIL b2b_timeout dones=%0d exp=2", dc); end
        if (fall_at - rise_at != 3) begin
            n_fail++; $display("FAIL b2b_gap got=%0d exp=3", fall_at - rise_at);
        end
        if (rx_word1 !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_rx1 got=%h exp=ffff", rx_word1); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_words_left got=%0d exp=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic p_sck;
        int rises, low, ra, da, dc, rs;
        logic [15:0] r0, r1;
        bit hit;
        rises = 0; hit = 0;
        loop_mode = 1'b1;
        exp_q.push_back(16'hC3C3);
        exp_q.push_back(16'h3C3C);
        @(negedge CLK);
        cmd = 16'hC3C3; value = 16'h3C3C; single = 1'b0; start = 1'b1;
        p_sck = SCK;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            start = 1'b0;
            if (SCK && !p_sck) rises++;
            p_sck = SCK;
            if (rises == 8) begin
                hit = 1;
                break;
            end
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        n_tests += 5;
        if (!hit) begin n_fail++; $display("FAIL midrst_reach rises=%0d exp=8", rises); end
        if (SCK !== 1'b1) begin n_fail++; $display("FAIL midrst_sck got=%b exp=1", SCK); end
        if (SCSN !== 1'b1) begin n_fail++; $display("FAIL midrst_scsn got=%b exp=1", SCSN); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (MOSI !== 1'b0) begin n_fail++; $display("FAIL midrst_mosi got=%b exp=0", MOSI); end
        @(negedge CLK);
        RST_N = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        exp_q.push_back(16'h0F0F);
        exp_q.push_back(16'h8001);
        run_frame(16'h0F0F, 16'h8001, 1'b0, -1, low, ra, da, dc, rs, r0, r1);
        n_tests += 3;
        if (r0 !== 16'h0F0F) begin n_fail++; $display("FAIL midrst_rx0 got=%h exp=0f0f", r0); end
        if (r1 !== 16'h8001) begin n_fail++; $display("FAIL midrst_rx1 got=%h exp=8001", r1); end
        if (low != 136) begin n_fail++; $display("FAIL midrst_scsn_low got=%0d exp=136", low); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_pair();
        test_loopback();
        test_single();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
